uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver for 8N1 framing, the receive-side counterpart of the UART transmitter in the same serial link. It synchronises the `rx` line into the `clk` domain, qualifies the start bit, samples eight data bits LSB-first plus one stop bit at bit centres, and presents each received byte with a one-cycle `rx_valid` strobe. Frames whose stop bit is low are discarded and flagged with `rx_frame_err`.

## Interface
- `clk_rate`, default 50000000: system clock frequency in Hz.
- `baud_rate`, default 115200: line bit rate.
- `clk_div`, default `clk_rate / baud_rate`: clocks per bit. It must be ≥4; `clk_div/2` is integer division.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: reset, **asynchronous, active-high**.
- `rx` input 1: serial line; asynchronous to `clk`; idle high.
- `rx_dout` output 8: last correctly received byte.
- `rx_valid` output 1: one-cycle pulse when `rx_dout` is updated.
- `rx_busy` output 1: high while a frame is being received.
- `rx_frame_err` output 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchroniser:** two flops, `rx` → `rx_s`, both reset to 0. All decisions use `rx_s`. Pin-to-`rx_s` latency is 2 cycles.
- **Registers:** `clk_cnt` is 17 bits, `data_index` is 3 bits, and `shift_reg` is 8 bits.

**States**
- `RX_WAIT` (the reset state)
  - `rx_busy`=0.
  - Go to `RX_IDLE` when `rx_s`==1.
  - This prevents a line held low or a mid-frame reset from being taken as a start bit.
- `RX_IDLE`
  - `rx_busy`=0, `clk_cnt`<=0, `data_index`<=0.
  - If `rx_s`==0, go to `RX_START` and set `rx_busy`<=1.
- `RX_START`
  - If `clk_cnt`==`clk_div/2`−1 and `rx_s`==0 (start bit confirmed at its centre): `clk_cnt`<=0, go to `RX_DATA`.
  - If `clk_cnt`==`clk_div/2`−1 and `rx_s`==1 (glitch): go to `RX_IDLE` and set `rx_busy`<=0. No strobe is produced.
  - Otherwise `clk_cnt`++.
- `RX_DATA`
  - At `clk_cnt`==`clk_div`−1: `shift_reg[data_index]`<=`rx_s` and `clk_cnt`<=0.
  - If `data_index`==7, go to `RX_STOP` and set `data_index`<=0. Otherwise `data_index`++.
  - Otherwise `clk_cnt`++.
- `RX_STOP`
  - At `clk_cnt`==`clk_div`−1, `rx_busy`<=0 and:
    - if `rx_s`==1: `rx_dout`<=`shift_reg`, `rx_valid`<=1, go to `RX_IDLE`.
    - if `rx_s`==0: `rx_frame_err`<=1, `rx_dout` is unchanged, go to `RX_WAIT`.
  - Otherwise `clk_cnt`++.
- **Unused encodings:** go to `RX_WAIT`.

**Output rules**
- `rx_valid` and `rx_frame_err` default to 0 every cycle and are never high together.
- `rx_dout` holds its value until the next good frame.
- **Back-to-back frames:** the return to `RX_IDLE` at the stop-bit centre leaves half a bit to detect the next start edge. No idle gap is required.

**Reset**
- Any state goes immediately to `RX_WAIT`.
- Reset values: `rx_dout`=0x00, `rx_valid`=0, `rx_busy`=0, `rx_frame_err`=0, `clk_cnt`=0, `data_index`=0, `shift_reg`=0.
- A partial frame in progress is discarded.

## Timing
- **Reference point:** cycle 0 is the `RX_IDLE` cycle in which `rx_s`==0 is seen; this is 2 cycles after the pin falls.
- **Start-bit check:** at cycle `clk_div/2`.
- **Data bit i (0..7):** sampled at cycle `clk_div/2` + (i+1)·`clk_div`.
- **Stop bit:** sampled at cycle `clk_div/2` + 9·`clk_div`.
- **Strobe:** `rx_valid` or `rx_frame_err` is high, and `rx_busy` is low, from the next cycle for exactly one cycle.
- **`rx_busy`:** high from cycle 1 through the stop-sample cycle.
- **Worked example, `clk_div`=16:** start check at cycle 8; bit 0 at cycle 24; stop at cycle 152; strobe at cycle 153, i.e. 155 cycles after the pin edge.
- **Glitch rejection:** a low pulse shorter than about `clk_div/2` clocks causes no strobe. `rx_busy` returns low at cycle `clk_div/2`+1.

## Test plan
- Use `clk_rate`=1600000 and `baud_rate`=100000 (`clk_div`=16) for all scenarios.
1. **Reset/idle:** assert `rst` with `rx`=1, then release → all outputs 0. Check `RX_WAIT`→`RX_IDLE` within 3 cycles and no strobes while idle.
2. **Single frame:** send byte 0xA5 → exactly one `rx_valid` pulse, 155 cycles after the falling edge, with `rx_dout`=0xA5 and `rx_frame_err` never set.
3. **Back-to-back frames:** send 0x00, 0xFF and 0x3C with no idle gap → three `rx_valid` pulses 160 cycles apart, with `rx_dout` = 0x00, 0xFF, 0x3C in that order.
4. **Glitch:** drive `rx` low for 4 cycles while idle → no `rx_valid`, no `rx_frame_err`; `rx_busy` pulses high and then low. A following 0x5A frame is received correctly.
5. **Framing error:**
   - Send 0x81 with the stop bit low and the line held low for 3 more bits → one `rx_frame_err` pulse; `rx_dout` keeps its previous value; no new frame starts while the line stays low.
   - After the line returns high, 0x81 sent with a correct stop bit is received.
6. **Reset mid-frame:** pulse `rst` during bit 4 of a 0x55 frame → outputs go to reset values at once. The rest of the frame produces no `rx_valid` carrying 0x55, and the next clean frame, 0xC3, is received.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, qualifies the start bit at its centre,
// samples eight data bits LSB-first plus a stop bit, and strobes each byte.
module uart_rx #(
  parameter int clk_rate  = 50000000,
  parameter int baud_rate = 115200,
  parameter int clk_div   = clk_rate / baud_rate
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_dout,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err
);

  localparam logic [16:0] half_m1 = 17'(clk_div / 2 - 1);
  localparam logic [16:0] bit_m1  = 17'(clk_div - 1);

  typedef enum logic [2:0] {
    RX_WAIT  = 3'd0,
    RX_IDLE  = 3'd1,
    RX_START = 3'd2,
    RX_DATA  = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_t;

  rx_state_t   state, state_nx;
  logic        rx_meta, rx_s;
  logic [16:0] clk_cnt, clk_cnt_nx;
  logic [2:0]  data_index, data_index_nx;
  logic [7:0]  shift_reg, shift_nx;
  logic [7:0]  dout_nx;
  logic        valid_nx, busy_nx, ferr_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RX_WAIT;
      clk_cnt      <= '0;
      data_index   <= '0;
      shift_reg    <= '0;
      rx_dout      <= '0;
      rx_valid     <= 1'b0;
      rx_busy      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nx;
      clk_cnt      <= clk_cnt_nx;
      data_index   <= data_index_nx;
      shift_reg    <= shift_nx;
      rx_dout      <= dout_nx;
      rx_valid     <= valid_nx;
      rx_busy      <= busy_nx;
      rx_frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    clk_cnt_nx    = clk_cnt;
    data_index_nx = data_index;
    shift_nx      = shift_reg;
    dout_nx       = rx_dout;
    valid_nx      = 1'b0;
    ferr_nx       = 1'b0;
    busy_nx       = rx_busy;
    case (state)
      // Wait for a high line so a stuck-low rx is never taken as a start bit.
      RX_WAIT: begin
        busy_nx = 1'b0;
        if (rx_s) state_nx = RX_IDLE;
      end
      RX_IDLE: begin
        busy_nx       = 1'b0;
        clk_cnt_nx    = '0;
        data_index_nx = '0;
        if (!rx_s) begin
          state_nx = RX_START;
          busy_nx  = 1'b1;
        end
      end
      RX_START: begin
        if (clk_cnt == half_m1) begin
          if (!rx_s) begin
            clk_cnt_nx = '0;
            state_nx   = RX_DATA;
          end else begin
            state_nx = RX_IDLE;
            busy_nx  = 1'b0;
          end
        end else begin
          clk_cnt_nx = clk_cnt + 17'd1;
        end
      end
      RX_DATA: begin
        if (clk_cnt == bit_m1) begin
          shift_nx[data_index] = rx_s;
          clk_cnt_nx           = '0;
          if (data_index == 3'd7) begin
            state_nx      = RX_STOP;
            data_index_nx = '0;
          end else begin
            data_index_nx = data_index + 3'd1;
          end
        end else begin
          clk_cnt_nx = clk_cnt + 17'd1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == bit_m1) begin
          busy_nx    = 1'b0;
          clk_cnt_nx = '0;
          if (rx_s) begin
            dout_nx  = shift_reg;
            valid_nx = 1'b1;
            state_nx = RX_IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = RX_WAIT;
          end
        end else begin
          clk_cnt_nx = clk_cnt + 17'd1;
        end
      end
      default: state_nx = RX_WAIT;
    endcase
  end

endmodule
